// File: rtl/mem_responder.sv
// Word-addressed memory responder with a 4-phase request/acknowledge handshake,
// fixed access latency, saturating access counters and a queued maintenance
// operation (counter clear or full array clear).
module mem_responder #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       IDX_W    = 8,
    parameter int unsigned       LATENCY  = 4,
    parameter logic [DATA_W-1:0] BAD_WORD = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request,
    input  logic              MEM_WE,
    input  logic [31:0]       addressBus,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic              MEM_ACK,
    output logic              err,
    input  logic              op_request,
    input  logic [3:0]        OPERATIONS,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int unsigned Words    = 2 ** IDX_W;
    localparam logic [3:0]  OpClrCnt = 4'b0011;
    localparam logic [3:0]  OpClrMem = 4'b0010;

    typedef enum logic [1:0] {StIdle, StWait, StAck, StClear} state_e;

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                pend_q, pend_d;
    logic [3:0]          op_q, op_d;
    logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;

    logic [DATA_W-1:0]   mem [Words];
    logic                mem_wr_en;
    logic [IDX_W-1:0]    mem_wr_idx;
    logic [DATA_W-1:0]   mem_wr_data;

    logic                in_range;
    logic [IDX_W-1:0]    addr_idx;

    assign in_range = (addr_q >> (IDX_W + 2)) == 32'd0;
    assign addr_idx = addr_q[IDX_W+1:2];

    // Next-state, access execution and maintenance-operation service
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        pend_d      = pend_q;
        op_d        = op_q;
        clr_idx_d   = clr_idx_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        mem_wr_en   = 1'b0;
        mem_wr_idx  = addr_idx;
        mem_wr_data = wdata_q;

        unique case (state_q)
            StIdle: begin
                // A pending access always wins over a pending operation
                if (request) begin
                    addr_d  = addressBus;
                    we_d    = MEM_WE;
                    wdata_d = dataBus;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end else if (pend_q) begin
                    pend_d = 1'b0;
                    if (op_q == OpClrCnt) begin
                        rd_count_d = '0;
                        wr_count_d = '0;
                    end else if (op_q == OpClrMem) begin
                        clr_idx_d = '0;
                        state_d   = StClear;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    err_d   = !in_range;
                    if (we_q) begin
                        mem_wr_en = in_range;
                        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        rdata_d = in_range ? mem[addr_idx] : BAD_WORD;
                        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                if (!request) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StClear: begin
                mem_wr_en   = 1'b1;
                mem_wr_idx  = clr_idx_q;
                mem_wr_data = '0;
                clr_idx_d   = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A fresh strobe overrides any code still waiting for service
        if (op_request) begin
            pend_d = 1'b1;
            op_d   = OPERATIONS;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            op_q       <= '0;
            clr_idx_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            op_q       <= op_d;
            clr_idx_q  <= clr_idx_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage array; not reset, and write enable is dead while state is held in idle by reset
    always_ff @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_idx] <= mem_wr_data;
    end

    assign dataBus  = (state_q == StAck && !we_q) ? rdata_q : 'z;
    assign MEM_ACK  = (state_q == StAck);
    assign err      = err_q;
    assign busy     = (state_q == StClear);
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning data bus width.
REQ-002 The module SHALL have parameter IDX_W, default 8, meaning word index width; the array holds 2^IDX_W words.
REQ-003 The module SHALL have parameter LATENCY, default 4, meaning cycles from accepted request to ACK; legal range 1..15.
REQ-004 The module SHALL have parameter BAD_WORD, default 32'hDEADBEEF, meaning read data for out-of-range addresses.
REQ-005 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-006 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-007 Port request  input  1  is the initiator access request, level, 4-phase.
REQ-008 Port MEM_WE  input  1  selects the access: 1 = write, 0 = read.
REQ-009 Port addressBus  input  32  is the byte address; bits [1:0] are ignored.
REQ-010 Port dataBus  inout  DATA_W  carries write data from the initiator and read data to it.
REQ-011 Port MEM_ACK  output  1  is the completion acknowledge.
REQ-012 Port err  output  1  flags an out-of-range access; valid while MEM_ACK=1.
REQ-013 Port op_request  input  1  is the maintenance-operation strobe.
REQ-014 Port OPERATIONS  input  4  is the maintenance-operation code.
REQ-015 Port busy  output  1  is high while a clear sweep runs.
REQ-016 Port rd_count  output  16  is the count of completed reads.
REQ-017 Port wr_count  output  16  is the count of completed writes.

Function
REQ-018 The module SHALL implement the states IDLE, WAIT, ACK and CLEAR.
REQ-019 In IDLE with request=1 sampled, the module SHALL latch addressBus, MEM_WE and dataBus, load the latency counter with LATENCY-1 and enter WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at 0 the access SHALL execute and the state SHALL become ACK, with MEM_ACK=1 from the next edge.
REQ-021 With request sampled high at edge N, MEM_ACK SHALL rise after edge N+LATENCY.
REQ-022 An address is in range iff latched addr[31:IDX_W+2]==0; the index SHALL be addr[IDX_W+1:2].
REQ-023 An in-range write SHALL store the latched data and increment wr_count.
REQ-024 An in-range read SHALL register the array word as read data and increment rd_count.
REQ-025 An out-of-range access SHALL set err=1, SHALL NOT modify the array, SHALL return BAD_WORD on a read, and SHALL increment the matching counter.
REQ-026 Both counters SHALL saturate at 16'hFFFF.
REQ-027 dataBus SHALL be driven with read data only when state=ACK and the latched WE=0; otherwise it SHALL be high-impedance.
REQ-028 In ACK, MEM_ACK and err SHALL hold until request is sampled low; then both SHALL clear on that edge and the state SHALL return to IDLE.
REQ-029 A new request SHALL be accepted no earlier than the first IDLE cycle after MEM_ACK falls.
REQ-030 If request drops during WAIT, the access SHALL still complete; ACK SHALL then last exactly one cycle.
REQ-031 A cycle with op_request=1 SHALL set a pending flag and capture OPERATIONS; a later op_request before service SHALL overwrite the captured code.
REQ-032 The pending operation SHALL be served only in IDLE with request=0; when request and a pending operation coincide, the request SHALL be served first.
REQ-033 Code 4'b0011 SHALL clear both counters in one cycle.
REQ-034 Code 4'b0010 SHALL enter CLEAR, write 0 to index 0..2^IDX_W-1 at one word per cycle with busy=1, then return to IDLE.
REQ-035 All other codes SHALL be consumed with no effect.
REQ-036 Requests arriving during CLEAR SHALL wait and be accepted in the first IDLE cycle afterwards.

Reset
REQ-037 On rst_n=0, asynchronously: state=IDLE, MEM_ACK=0, err=0, busy=0, counters=0, pending flag=0, dataBus=Z.
REQ-038 Reset SHALL NOT initialise array contents; a reset mid-access or mid-CLEAR SHALL abort it with no further array writes.

Verification
REQ-039 Write 32'h00000002 to addr 32'h10, then read addr 32'h10 -> MEM_ACK rises 4 cycles after each request; read data 32'h00000002; wr_count=1, rd_count=1.
REQ-040 Read addr 32'h00010000 -> err=1 with MEM_ACK, dataBus=32'hDEADBEEF; array unchanged.
REQ-041 request held high after ACK -> MEM_ACK stays 1 until request falls, then drops in 1 cycle; no second access.
REQ-042 op_request with 4'b0010 while a read is in WAIT -> read completes first; then busy=1 for 256 cycles; subsequent read of addr 32'h10 returns 0.
REQ-043 rst_n pulsed low during WAIT of a write -> MEM_ACK never rises, counters=0, target word keeps its prior value.
REQ-044 op_request with 4'b0011 after 3 reads -> rd_count=0 next cycle.
